// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over req/gnt + rvalid and queues
// {instruction, PC} pairs for decode. Optional misaligned-PC fault: define FETCH_ALIGN_CHK_EN.
module instr_fetch_unit #(
    parameter logic [31:0] PC_START = 32'h00400020,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_out,
    output logic [31:0] ins_pc,
    output logic        fetch_fault
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FAULT} state_t;

    state_t         state_reg, state_next;
    logic [31:0]    pc_reg, pc_next;
    logic [31:0]    req_pc_reg;
    logic           drop_reg, drop_next;
    logic [CW-1:0]  count_reg, count_next;
    logic [PW-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [63:0]    buf_mem [DEPTH];

    logic flush, fire, resp, push, pop, addr_ok, in_flight;

`ifdef FETCH_ALIGN_CHK_EN
    assign addr_ok     = (pc_reg[1:0] == 2'b00);
    assign fetch_fault = (state_reg == S_FAULT);
`else
    assign addr_ok     = 1'b1;
    assign fetch_fault = 1'b0;
`endif

    assign flush     = load_pc | redirect_valid;
    assign imem_req  = (state_reg == S_REQ) && (count_reg < CW'(DEPTH)) && addr_ok;
    assign fire      = imem_req & imem_gnt;
    assign resp      = (state_reg == S_WAIT) & imem_rvalid;
    assign push      = resp & ~drop_reg & ~flush;
    assign ins_valid = (count_reg != '0);
    assign pop       = ins_valid & ins_ready;
    // A response arriving in the flush cycle closes the outstanding request, so no drop is needed.
    assign in_flight = ((state_reg == S_WAIT) & ~imem_rvalid) | fire;

    // PC is held at PC_START during reset, but the address bus must read zero.
    assign imem_addr = reset ? pc_reg : 32'h0;
    assign ins_out   = ins_valid ? buf_mem[rd_ptr_reg][63:32] : 32'h0;
    assign ins_pc    = ins_valid ? buf_mem[rd_ptr_reg][31:0]  : 32'h0;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        drop_next  = drop_reg;
        case (state_reg)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                if (!addr_ok) begin
                    state_next = S_FAULT;
                end else if (fire) begin
                    pc_next    = pc_reg + 32'd4;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    drop_next  = 1'b0;
                    state_next = S_REQ;
                end
            end
            default: state_next = state_reg;
        endcase
        if (flush) begin
            pc_next    = load_pc ? PC_START : redirect_pc;
            drop_next  = in_flight;
            state_next = in_flight ? S_WAIT : S_REQ;
        end
    end

    always_comb begin
        count_next  = count_reg + CW'(push) - CW'(pop);
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (pop)
            rd_ptr_next = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
        if (push)
            wr_ptr_next = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
        if (flush) begin
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= S_IDLE;
            pc_reg     <= PC_START;
            req_pc_reg <= 32'h0;
            drop_reg   <= 1'b0;
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            drop_reg   <= drop_next;
            count_reg  <= count_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            if (fire)
                req_pc_reg <= pc_reg;
        end
    end

    // Storage needs no reset: entries are only visible while counted valid.
    always_ff @(posedge clk) begin
        if (push)
            buf_mem[wr_ptr_reg] <= {imem_rdata, req_pc_reg};
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed cycle tables plus randomized traffic checked
// against a transaction-level model of PC, outstanding request and instruction queue.
module tb_instr_fetch_unit;

    localparam logic [31:0] PS    = 32'h00400020;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_pc = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'h0;
    logic        ins_valid, ins_ready = 1'b0, fetch_fault;
    logic [31:0] ins_out, ins_pc;

    int checks = 0;
    int failures = 0;

    instr_fetch_unit #(.PC_START(PS), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .load_pc(load_pc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_out(ins_out), .ins_pc(ins_pc),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        rst_n, ld, rd;
        logic [31:0] rpc;
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_out, e_pc;
        logic        e_fault;
    } vec_t;

    vec_t tbl [27];
    vec_t seq6 [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        reset          = v.rst_n;
        load_pc        = v.ld;
        redirect_valid = v.rd;
        redirect_pc    = v.rpc;
        imem_gnt       = v.gnt;
        imem_rvalid    = v.rv;
        imem_rdata     = v.rdata;
        ins_ready      = v.rdy;
        #1;
        chk({tag, " imem_req"},    imem_req,    v.e_req);
        chk({tag, " imem_addr"},   imem_addr,   v.e_addr);
        chk({tag, " ins_valid"},   ins_valid,   v.e_iv);
        chk({tag, " ins_out"},     ins_out,     v.e_out);
        chk({tag, " ins_pc"},      ins_pc,      v.e_pc);
        chk({tag, " fetch_fault"}, fetch_fault, v.e_fault);
        $display("vec %s req=%0b addr=%h iv=%0b out=%h pc=%h fault=%0b", tag,
                 imem_req, imem_addr, ins_valid, ins_out, ins_pc, fetch_fault);
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
    endfunction

    // Reference model state
    logic [31:0] pc_m;
    logic [63:0] q_m [$];
    bit          pend, pend_stale, started, fault_m;
    logic [31:0] pend_addr;
    int          pend_dly;

    initial begin
        //          rst ld rd rpc           gnt rv rdata         rdy  req addr          iv out           pc            flt
        tbl[0]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        32'h0,        0};
        tbl[1]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        0,   0, PS,           0, 32'h0,        32'h0,        0};
        tbl[2]  = '{1, 0, 0, 32'h0,        1, 0, 32'h0,        0,   1, PS,           0, 32'h0,        32'h0,        0};
        tbl[3]  = '{1, 0, 0, 32'h0,        0, 1, 32'h20080005, 0,   0, 32'h00400024, 0, 32'h0,        32'h0,        0};
        tbl[4]  = '{1, 0, 0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h00400024, 1, 32'h20080005, PS,           0};
        tbl[5]  = '{1, 0, 0, 32'h0,        0, 1, 32'h11111111, 0,   0, 32'h00400028, 1, 32'h20080005, PS,           0};
        tbl[6]  = '{1, 0, 0, 32'h0,        1, 0, 32'h0,        0,   0, 32'h00400028, 1, 32'h20080005, PS,           0};
        tbl[7]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h00400028, 1, 32'h20080005, PS,           0};
        tbl[8]  = '{1, 0, 0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h00400028, 1, 32'h11111111, 32'h00400024, 0};
        tbl[9]  = '{1, 0, 0, 32'h0,        0, 1, 32'h22222222, 1,   0, 32'h0040002C, 1, 32'h11111111, 32'h00400024, 0};
        tbl[10] = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h0040002C, 1, 32'h22222222, 32'h00400028, 0};
        tbl[11] = '{1, 0, 0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h0040002C, 0, 32'h0,        32'h0,        0};
        tbl[12] = '{1, 0, 1, 32'h00400100, 0, 0, 32'h0,        0,   0, 32'h00400030, 0, 32'h0,        32'h0,        0};
        tbl[13] = '{1, 0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 0,   0, 32'h00400100, 0, 32'h0,        32'h0,        0};
        tbl[14] = '{1, 0, 0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h00400100, 0, 32'h0,        32'h0,        0};
        tbl[15] = '{1, 0, 0, 32'h0,        0, 1, 32'h33333333, 0,   0, 32'h00400104, 0, 32'h0,        32'h0,        0};
        tbl[16] = '{1, 0, 0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h00400104, 1, 32'h33333333, 32'h00400100, 0};
        tbl[17] = '{1, 0, 0, 32'h0,        0, 1, 32'h44444444, 0,   0, 32'h00400108, 1, 32'h33333333, 32'h00400100, 0};
        tbl[18] = '{1, 1, 0, 32'h0,        0, 0, 32'h0,        1,   0, 32'h00400108, 1, 32'h33333333, 32'h00400100, 0};
        tbl[19] = '{1, 1, 1, 32'h00500000, 1, 0, 32'h0,        0,   1, PS,           0, 32'h0,        32'h0,        0};
        tbl[20] = '{1, 0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 0,   0, PS,           0, 32'h0,        32'h0,        0};
        tbl[21] = '{1, 0, 0, 32'h0,        1, 0, 32'h0,        0,   1, PS,           0, 32'h0,        32'h0,        0};
        tbl[22] = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h00400024, 0, 32'h0,        32'h0,        0};
        tbl[23] = '{0, 0, 0, 32'h0,        0, 0, 32'h0,        0,   0, 32'h0,        0, 32'h0,        32'h0,        0};
        tbl[24] = '{1, 0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 0,   0, PS,           0, 32'h0,        32'h0,        0};
        tbl[25] = '{1, 0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 0,   1, PS,           0, 32'h0,        32'h0,        0};
        tbl[26] = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        0,   1, PS,           0, 32'h0,        32'h0,        0};

`ifdef FETCH_ALIGN_CHK_EN
        seq6[0] = '{1, 0, 1, 32'h00400102, 0, 0, 32'h0,        0,   1, PS,           0, 32'h0,        32'h0,        0};
        seq6[1] = '{1, 0, 0, 32'h0,        1, 0, 32'h0,        0,   0, 32'h00400102, 0, 32'h0,        32'h0,        0};
        seq6[2] = '{1, 0, 0, 32'h0,        1, 0, 32'h0,        0,   0, 32'h00400102, 0, 32'h0,        32'h0,        1};
        seq6[3] = '{1, 0, 1, 32'h00400104, 1, 0, 32'h0,        0,   0, 32'h00400102, 0, 32'h0,        32'h0,        1};
        seq6[4] = '{1, 0, 0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h00400104, 0, 32'h0,        32'h0,        0};
        seq6[5] = '{1, 0, 0, 32'h0,        0, 1, 32'h55555555, 0,   0, 32'h00400108, 0, 32'h0,        32'h0,        0};
        seq6[6] = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h00400108, 1, 32'h55555555, 32'h00400104, 0};
`else
        seq6[0] = '{1, 0, 1, 32'h00400102, 0, 0, 32'h0,        0,   1, PS,           0, 32'h0,        32'h0,        0};
        seq6[1] = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        0,   1, 32'h00400102, 0, 32'h0,        32'h0,        0};
        seq6[2] = '{1, 0, 0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h00400102, 0, 32'h0,        32'h0,        0};
        seq6[3] = '{1, 0, 1, 32'h00400104, 0, 1, 32'h66666666, 0,   0, 32'h00400106, 0, 32'h0,        32'h0,        0};
        seq6[4] = '{1, 0, 0, 32'h0,        1, 0, 32'h0,        0,   1, 32'h00400104, 0, 32'h0,        32'h0,        0};
        seq6[5] = '{1, 0, 0, 32'h0,        0, 1, 32'h55555555, 0,   0, 32'h00400108, 0, 32'h0,        32'h0,        0};
        seq6[6] = '{1, 0, 0, 32'h0,        0, 0, 32'h0,        1,   1, 32'h00400108, 1, 32'h55555555, 32'h00400104, 0};
`endif

        for (int i = 0; i < 27; i++)
            apply(tbl[i], $sformatf("t%0d", i));
        for (int i = 0; i < 7; i++)
            apply(seq6[i], $sformatf("align%0d", i));

        // Randomized traffic against the transaction-level model
        @(negedge clk);
        reset = 1'b0; load_pc = 1'b0; redirect_valid = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; ins_ready = 1'b0;
        #1;
        pc_m = PS; q_m.delete(); pend = 0; pend_stale = 0; started = 0; fault_m = 0;
        pend_addr = 32'h0; pend_dly = 0;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            bit          flush_m, fire_m, in_req, exp_req, misal;
            logic [31:0] exp_out, exp_pc;
            int          r;
            @(negedge clk);
            reset     = 1'b1;
            imem_gnt  = ($urandom_range(0, 3) != 0);
            ins_ready = ($urandom_range(0, 2) != 0);
            r = $urandom_range(0, 99);
            load_pc        = (r < 3);
            redirect_valid = (r == 0) || (r >= 3 && r < 9);
            r = $urandom_range(0, 19);
            if (r == 0)
                redirect_pc = 32'hFFFFFFF8;
            else if (r == 1)
                redirect_pc = {16'h0040, 14'($urandom), 2'($urandom_range(1, 3))};
            else
                redirect_pc = {16'h0040, 14'($urandom), 2'b00};
            if (pend && pend_dly == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word_of(pend_addr);
            end else if (!pend) begin
                imem_rvalid = ($urandom_range(0, 9) == 0);
                imem_rdata  = 32'hDEADBEEF;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
            #1;
`ifdef FETCH_ALIGN_CHK_EN
            misal = (pc_m[1:0] != 2'b00);
`else
            misal = 1'b0;
`endif
            in_req  = started && !pend && !fault_m;
            exp_req = in_req && !misal && (q_m.size() < DEPTH);
            exp_out = (q_m.size() > 0) ? q_m[0][63:32] : 32'h0;
            exp_pc  = (q_m.size() > 0) ? q_m[0][31:0]  : 32'h0;
            chk($sformatf("rnd%0d imem_req", cyc),    imem_req,    exp_req);
            chk($sformatf("rnd%0d imem_addr", cyc),   imem_addr,   pc_m);
            chk($sformatf("rnd%0d ins_valid", cyc),   ins_valid,   q_m.size() > 0);
            chk($sformatf("rnd%0d ins_out", cyc),     ins_out,     exp_out);
            chk($sformatf("rnd%0d ins_pc", cyc),      ins_pc,      exp_pc);
            chk($sformatf("rnd%0d fetch_fault", cyc), fetch_fault, fault_m);
            if (cyc % 100 == 0)
                $display("rnd %0d req=%0b addr=%h iv=%0b out=%h pc=%h queued=%0d", cyc,
                         imem_req, imem_addr, ins_valid, ins_out, ins_pc, q_m.size());

            // Model the effect of the coming rising edge
            flush_m = load_pc || redirect_valid;
            fire_m  = exp_req && imem_gnt;
            if (q_m.size() > 0 && ins_ready)
                void'(q_m.pop_front());
            if (pend && pend_dly == 0) begin
                if (!pend_stale && !flush_m)
                    q_m.push_back({word_of(pend_addr), pend_addr});
                pend = 0;
            end else if (pend) begin
                pend_dly--;
            end
            if (in_req && misal && !flush_m)
                fault_m = 1;
            if (fire_m) begin
                pend       = 1;
                pend_addr  = pc_m;
                pend_dly   = $urandom_range(0, 2);
                pend_stale = 0;
                pc_m       = pc_m + 32'd4;
            end
            if (flush_m) begin
                q_m.delete();
                if (pend)
                    pend_stale = 1;
                pc_m    = load_pc ? PS : redirect_pc;
                fault_m = 0;
            end
            started = 1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
